// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CSUM,
    DONE
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;
  localparam logic [7:0] CSUM_INIT = 8'h00;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream and imem-write bus of the instruction-memory loader.
// The master is the stream source / system side, the slave is the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
) ();

  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs a big-endian byte stream into one instruction word; full_o flags
// that the next shifted byte completes the word.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        shift_en_i,
  input  logic                        clear_i,
  input  logic [7:0]                  byte_i,
  output logic [BYTES_PER_WORD*8-1:0] word_o,
  output logic                        full_o
);

  logic [BYTES_PER_WORD*8-1:0] word_q;
  logic [1:0]                  idx_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (clear_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (shift_en_i) begin
      word_q <= {word_q[BYTES_PER_WORD*8-9:0], byte_i};
      idx_q  <= idx_q + 2'd1;
    end
  end

  assign word_o = word_q;
  assign full_o = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds the CPU
// until done. Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
) (
  input logic          clock,
  input logic          reset_n,
  imem_loader_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     wcnt_q, wcnt_d;
  logic                error_q, error_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic                byte_ready;
  logic                accept;
  logic [LEN_W-1:0]    len_full;
  logic                last_word;
  logic                pack_shift;
  logic                pack_clear;
  logic                pack_full;
  logic [WORD_W-1:0]   pack_word;

  imem_loader_byte_packer u_packer (
    .clock      (clock),
    .reset_n    (reset_n),
    .shift_en_i (pack_shift),
    .clear_i    (pack_clear),
    .byte_i     (bus.byte_in),
    .word_o     (pack_word),
    .full_o     (pack_full)
  );

  assign byte_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                      (state_q == DATA)   || (state_q == CSUM);
  assign accept     = byte_ready && bus.byte_valid;
  assign len_full   = {count_q[LEN_W-1:8], bus.byte_in};
  assign last_word  = (LEN_W'(wcnt_q) + LEN_W'(1)) == count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      error_q <= 1'b0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= CSUM_INIT;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      error_q <= error_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    wcnt_d     = wcnt_q;
    error_d    = error_q;
    wdata_d    = wdata_q;
    pack_shift = 1'b0;
    pack_clear = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d    = LEN_HI;
          error_d    = 1'b0;
          count_d    = '0;
          addr_d     = '0;
          wcnt_d     = '0;
          pack_clear = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d     = CSUM_INIT;
`endif
        end
      end
      LEN_HI: begin
        if (accept) begin
          count_d = {bus.byte_in, 8'h00};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          count_d = len_full;
          if (len_full == '0) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else if (int'(len_full) > DEPTH) begin
            // Oversized programs are rejected before anything touches imem.
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            addr_d     = '0;
            wcnt_d     = '0;
            pack_clear = 1'b1;
            state_d    = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          pack_shift = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d     = csum_q ^ bus.byte_in;
`endif
          if (pack_full) state_d = WRITE;
        end
      end
      WRITE: begin
        wdata_d = pack_word;
        addr_d  = addr_q + ADDR_W'(1);
        wcnt_d  = wcnt_q + (ADDR_W + 1)'(1);
        if (last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_d = CSUM;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: begin
        if (accept) begin
          error_d = (bus.byte_in != csum_q);
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // The write word is shown live during WRITE and then held until the next one.
  assign bus.imem_wdata = (state_q == WRITE) ? pack_word : wdata_q;
  assign bus.byte_ready = byte_ready;
  assign bus.imem_we    = (state_q == WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.done       = (state_q == DONE);
  assign bus.error      = error_q;
  assign bus.cpu_hold   = !((state_q == DONE) && !error_q);

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader against a stream-parsing
// reference model; also honours IMEM_LOADER_CSUM_EN.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clock = 1'b0;
  logic reset_n;

  imem_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]        streamQ[$];
  logic [WORD_W-1:0] expData[$];
  logic              expErr;
  logic [ADDR_W-1:0] gotAddr[$];
  logic [WORD_W-1:0] gotData[$];
  int                readyDuringWrite;

  // Write monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset_n && bus.imem_we) begin
      gotAddr.push_back(bus.imem_addr);
      gotData.push_back(bus.imem_wdata);
      if (bus.byte_ready) readyDuringWrite++;
    end
  end

  // Reference model: parse the stream as length, words, optional checksum.
  task automatic buildExpected();
    int n;
    logic [7:0] x;
    logic [WORD_W-1:0] v;
    expData.delete();
    expErr = 1'b0;
    x = 8'h00;
    n = int'(streamQ[0]) * 256 + int'(streamQ[1]);
    if (n > DEPTH) begin
      expErr = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      v = '0;
      for (int b = 0; b < 4; b++) begin
        v = (v << 8) | WORD_W'(streamQ[2 + 4 * w + b]);
        x = x ^ streamQ[2 + 4 * w + b];
      end
      expData.push_back(v);
    end
`ifdef IMEM_LOADER_CSUM_EN
    expErr = (streamQ[2 + 4 * n] != x);
`endif
  endtask

  task automatic addCsum();
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < streamQ.size(); i++) x = x ^ streamQ[i];
    streamQ.push_back(x);
`endif
  endtask

  task automatic makeRandomStream(input int n);
    streamQ.delete();
    streamQ.push_back(8'(n >> 8));
    streamQ.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) streamQ.push_back(8'($urandom_range(255)));
    addCsum();
  endtask

  // Pulse start, then feed streamQ with random valid gaps; returns at the
  // negedge following acceptance of the last byte.
  task automatic applyStimulus(input int dropPct, input int busyStartAt, output bit ok);
    int idx;
    int cycles;
    bit acc;
    bit startUsed;
    gotAddr.delete();
    gotData.delete();
    readyDuringWrite = 0;
    idx = 0;
    cycles = 0;
    startUsed = 1'b0;
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    while (idx < streamQ.size() && cycles < 5000) begin
      bus.byte_in    = streamQ[idx];
      bus.byte_valid = ($urandom_range(99) >= dropPct);
      bus.start      = (idx == busyStartAt) && !startUsed;
      if (bus.start) startUsed = 1'b1;
      acc = bus.byte_valid && bus.byte_ready;
      @(negedge clock);
      if (acc) idx++;
      cycles++;
    end
    bus.byte_valid = 1'b0;
    bus.start      = 1'b0;
    ok = (idx == streamQ.size());
  endtask

  task automatic waitDone(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clock);
    compared++; if (bus.byte_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.byte_ready); end
    compared++; if (bus.imem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_we: got %b expected 0", bus.imem_we); end
    compared++; if (bus.imem_addr !== '0) begin mismatched++; $display("[TB] FAIL reset_addr: got %h expected 00", bus.imem_addr); end
    compared++; if (bus.imem_wdata !== '0) begin mismatched++; $display("[TB] FAIL reset_wdata: got %h expected 0", bus.imem_wdata); end
    compared++; if (bus.cpu_hold !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_hold: got %b expected 1", bus.cpu_hold); end
    compared++; if (bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    compared++; if (bus.error !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_error: got %b expected 0", bus.error); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic_load();
    bit ok, dn;
    streamQ = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    addCsum();
    buildExpected();
    applyStimulus(0, -1, ok);
    waitDone(20, dn);
    compared++; if (!(ok && dn)) begin mismatched++; $display("[TB] FAIL basic_timeout: sent %b done %b expected 1 1", ok, dn); end
    compared++; if (gotData.size() !== 2) begin mismatched++; $display("[TB] FAIL basic_count: got %0d writes expected 2", gotData.size()); end
    if (gotData.size() == 2) begin
      compared++; if (gotData[0] !== 32'h12345678 || gotAddr[0] !== 8'h00) begin mismatched++; $display("[TB] FAIL basic_w0: got %h@%h expected 12345678@00", gotData[0], gotAddr[0]); end
      compared++; if (gotData[1] !== 32'h9ABCDEF0 || gotAddr[1] !== 8'h01) begin mismatched++; $display("[TB] FAIL basic_w1: got %h@%h expected 9abcdef0@01", gotData[1], gotAddr[1]); end
    end
    compared++; if (bus.error !== 1'b0 || bus.cpu_hold !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_status: got err %b hold %b expected 0 0", bus.error, bus.cpu_hold); end
    @(negedge clock);
    compared++; if (bus.imem_wdata !== 32'h9ABCDEF0) begin mismatched++; $display("[TB] FAIL basic_wdata_hold: got %h expected 9abcdef0", bus.imem_wdata); end
  endtask

  task automatic test_backpressure();
    bit ok, dn;
    for (int r = 0; r < 3; r++) begin
      streamQ = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      addCsum();
      buildExpected();
      applyStimulus(40, -1, ok);
      waitDone(20, dn);
      compared++; if (!(ok && dn)) begin mismatched++; $display("[TB] FAIL bp_timeout: sent %b done %b expected 1 1", ok, dn); end
      compared++; if (gotData.size() !== expData.size()) begin mismatched++; $display("[TB] FAIL bp_count: got %0d expected %0d", gotData.size(), expData.size()); end
      for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
        compared++; if (gotData[i] !== expData[i] || gotAddr[i] !== ADDR_W'(i)) begin mismatched++; $display("[TB] FAIL bp_word%0d: got %h@%h expected %h@%h", i, gotData[i], gotAddr[i], expData[i], ADDR_W'(i)); end
      end
      compared++; if (readyDuringWrite !== 0) begin mismatched++; $display("[TB] FAIL bp_ready_in_write: got %0d cycles expected 0", readyDuringWrite); end
    end
  endtask

  task automatic test_random_loads();
    bit ok, dn;
    int n;
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(8, 1);
      makeRandomStream(n);
      buildExpected();
      applyStimulus(30, -1, ok);
      waitDone(20, dn);
      compared++; if (!(ok && dn)) begin mismatched++; $display("[TB] FAIL rand_timeout: sent %b done %b expected 1 1", ok, dn); end
      compared++; if (gotData.size() !== expData.size()) begin mismatched++; $display("[TB] FAIL rand_count: got %0d expected %0d", gotData.size(), expData.size()); end
      for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
        compared++; if (gotData[i] !== expData[i] || gotAddr[i] !== ADDR_W'(i)) begin mismatched++; $display("[TB] FAIL rand_word%0d: got %h@%h expected %h@%h", i, gotData[i], gotAddr[i], expData[i], ADDR_W'(i)); end
      end
      compared++; if (bus.error !== expErr || bus.cpu_hold !== expErr) begin mismatched++; $display("[TB] FAIL rand_status: got err %b hold %b expected %b %b", bus.error, bus.cpu_hold, expErr, expErr); end
    end
  endtask

  task automatic test_zero_len();
    bit ok, dn;
    streamQ = '{8'h00, 8'h00};
    addCsum();
    buildExpected();
    applyStimulus(0, -1, ok);
    waitDone(2, dn);
    compared++; if (!(ok && dn)) begin mismatched++; $display("[TB] FAIL zero_done: sent %b done %b expected 1 1", ok, dn); end
    compared++; if (gotData.size() !== 0) begin mismatched++; $display("[TB] FAIL zero_writes: got %0d expected 0", gotData.size()); end
    compared++; if (bus.error !== 1'b0 || bus.cpu_hold !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_status: got err %b hold %b expected 0 0", bus.error, bus.cpu_hold); end
  endtask

  task automatic test_overflow();
    bit ok, dn;
    streamQ = '{8'h01, 8'h01};
    buildExpected();
    applyStimulus(0, -1, ok);
    waitDone(2, dn);
    repeat (3) @(negedge clock);
    compared++; if (!(ok && dn)) begin mismatched++; $display("[TB] FAIL ovf_done: sent %b done %b expected 1 1", ok, dn); end
    compared++; if (bus.error !== expErr || bus.error !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_error: got %b expected 1", bus.error); end
    compared++; if (bus.cpu_hold !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_hold: got %b expected 1", bus.cpu_hold); end
    compared++; if (gotData.size() !== 0) begin mismatched++; $display("[TB] FAIL ovf_writes: got %0d expected 0", gotData.size()); end
  endtask

  task automatic test_full_depth();
    bit ok, dn;
    int bad;
    makeRandomStream(DEPTH);
    buildExpected();
    applyStimulus(0, -1, ok);
    waitDone(20, dn);
    compared++; if (!(ok && dn)) begin mismatched++; $display("[TB] FAIL full_timeout: sent %b done %b expected 1 1", ok, dn); end
    compared++; if (gotData.size() !== DEPTH) begin mismatched++; $display("[TB] FAIL full_count: got %0d expected %0d", gotData.size(), DEPTH); end
    bad = 0;
    for (int i = 0; i < expData.size() && i < gotData.size(); i++)
      if (gotData[i] !== expData[i] || gotAddr[i] !== ADDR_W'(i)) bad++;
    compared++; if (bad !== 0) begin mismatched++; $display("[TB] FAIL full_words: got %0d wrong words expected 0", bad); end
    compared++; if (bus.error !== 1'b0 || bus.cpu_hold !== 1'b0) begin mismatched++; $display("[TB] FAIL full_status: got err %b hold %b expected 0 0", bus.error, bus.cpu_hold); end
  endtask

  task automatic test_busy_start();
    bit ok, dn;
    makeRandomStream(2);
    buildExpected();
    applyStimulus(0, 5, ok);
    waitDone(20, dn);
    compared++; if (!(ok && dn)) begin mismatched++; $display("[TB] FAIL busy_timeout: sent %b done %b expected 1 1", ok, dn); end
    compared++; if (gotData.size() !== 2) begin mismatched++; $display("[TB] FAIL busy_count: got %0d expected 2", gotData.size()); end
    for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
      compared++; if (gotData[i] !== expData[i] || gotAddr[i] !== ADDR_W'(i)) begin mismatched++; $display("[TB] FAIL busy_word%0d: got %h@%h expected %h@%h", i, gotData[i], gotAddr[i], expData[i], ADDR_W'(i)); end
    end
  endtask

  task automatic test_reset_mid_load();
    bit ok, dn;
    logic [7:0] fullQ[$];
    makeRandomStream(2);
    fullQ = streamQ;
    streamQ = fullQ[0:7];
    applyStimulus(0, -1, ok);
    #2;
    reset_n = 1'b0;
    #1;
    compared++; if (bus.byte_ready !== 1'b0 || bus.imem_we !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_ctrl: got ready %b we %b done %b err %b expected 0 0 0 0", bus.byte_ready, bus.imem_we, bus.done, bus.error); end
    compared++; if (bus.imem_addr !== '0 || bus.imem_wdata !== '0) begin mismatched++; $display("[TB] FAIL midrst_bus: got %h@%h expected 0@00", bus.imem_wdata, bus.imem_addr); end
    compared++; if (bus.cpu_hold !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_hold: got %b expected 1", bus.cpu_hold); end
    @(negedge clock);
    reset_n = 1'b1;
    makeRandomStream(3);
    buildExpected();
    applyStimulus(20, -1, ok);
    waitDone(20, dn);
    compared++; if (!(ok && dn)) begin mismatched++; $display("[TB] FAIL midrst_reload: sent %b done %b expected 1 1", ok, dn); end
    compared++; if (gotData.size() !== 3) begin mismatched++; $display("[TB] FAIL midrst_count: got %0d expected 3", gotData.size()); end
    for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
      compared++; if (gotData[i] !== expData[i] || gotAddr[i] !== ADDR_W'(i)) begin mismatched++; $display("[TB] FAIL midrst_word%0d: got %h@%h expected %h@%h", i, gotData[i], gotAddr[i], expData[i], ADDR_W'(i)); end
    end
  endtask

`ifdef IMEM_LOADER_CSUM_EN
  task automatic test_csum();
    bit ok, dn;
    streamQ = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    buildExpected();
    applyStimulus(0, -1, ok);
    waitDone(10, dn);
    compared++; if (!(ok && dn) || bus.error !== 1'b0 || expErr !== 1'b0) begin mismatched++; $display("[TB] FAIL csum_good: got done %b err %b expected 1 0", dn, bus.error); end
    compared++; if (bus.cpu_hold !== 1'b0) begin mismatched++; $display("[TB] FAIL csum_good_hold: got %b expected 0", bus.cpu_hold); end
    streamQ = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    buildExpected();
    applyStimulus(0, -1, ok);
    waitDone(10, dn);
    compared++; if (!(ok && dn) || bus.error !== 1'b1 || expErr !== 1'b1) begin mismatched++; $display("[TB] FAIL csum_bad: got done %b err %b expected 1 1", dn, bus.error); end
    compared++; if (bus.cpu_hold !== 1'b1) begin mismatched++; $display("[TB] FAIL csum_bad_hold: got %b expected 1", bus.cpu_hold); end
    compared++; if (gotData.size() !== 1 || (gotData.size() == 1 && gotData[0] !== 32'h11223344)) begin mismatched++; $display("[TB] FAIL csum_bad_write: got %0d writes expected 1 of 11223344", gotData.size()); end
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, done %b expected 1", bus.done);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_load();
    test_backpressure();
    test_random_loads();
    test_zero_len();
    test_overflow();
    test_full_depth();
    test_busy_start();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CSUM_EN
    test_csum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
